// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port 160x120x8 frame-buffer RAM between VGA scan-out and
// a pixel writer, in the 25 MHz pixel-clock domain.
//
// Scan-out prefetches one RAM word per 4-pixel group, one group ahead of the
// beam. The word is shown for 4 pixels and 4 lines, giving 4x upscaling.
// Every RAM cycle that is not a read slot can be granted to the writer
// through a req/ack handshake.
//
// Ports
//   clock, reset        pixel clock; asynchronous active-high reset
//   next_x, next_y      coordinates of the next pixel, from vga_driver
//   color_out           RRRGGGBB pixel colour, to vga_driver color_in
//   frame_start         one-cycle pulse after the cycle with next = (0,0)
//   wr_req/wr_x/wr_y/   write request; held stable until wr_ack
//   wr_data
//   wr_ack              one-cycle grant pulse, coincident with mem_we
//   wr_err              sticky flag: an out-of-range write was granted
//   mem_addr/mem_we/    registered RAM port
//   mem_wdata
//   mem_rdata           RAM read data, valid after the edge that samples
//                       mem_addr
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int WR_BLANK_ONLY = 0,
    parameter int H_VIS         = 640,
    parameter int V_VIS         = 480
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  next_x,
    input  logic [9:0]  next_y,
    output logic [7:0]  color_out,
    output logic        frame_start,
    input  logic        wr_req,
    input  logic [7:0]  wr_x,
    input  logic [6:0]  wr_y,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic        wr_err,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam int FB_W = H_VIS / 4;
    localparam int FB_H = V_VIS / 4;

    localparam logic [9:0] H_LIM  = 10'(H_VIS);
    localparam logic [9:0] V_LIM  = 10'(V_VIS);
    localparam logic [7:0] G_LAST = 8'(FB_W - 1);
    localparam logic [7:0] R_LAST = 8'(FB_H - 1);
    localparam logic [7:0] X_LIM  = 8'(FB_W);
    localparam logic [6:0] Y_LIM  = 7'(FB_H);

    // Row base address r*160 as shift-and-add.
    function automatic logic [14:0] row_base(input logic [7:0] r);
        row_base = {r, 7'b0} + {2'b0, r, 5'b0};
    endfunction

    logic        vis;
    logic        slot;
    logic        blank_ok;
    logic        wr_in_range;
    logic [7:0]  grp;
    logic [7:0]  row;
    logic [14:0] fetch_addr;
    logic [14:0] wr_addr;

    logic [14:0] addr_nxt;
    logic        we_nxt;
    logic [7:0]  wdata_nxt;
    logic        ack_nxt;
    logic        err_nxt;

    logic        vld_p0;
    logic        vld_p1;
    logic [7:0]  hold;

    assign grp         = next_x[9:2];
    assign row         = next_y[9:2];
    assign vis         = (next_x < H_LIM) && (next_y < V_LIM);
    assign slot        = vis && (next_x[1:0] == 2'd0);
    assign blank_ok    = (WR_BLANK_ONLY == 0) || !vis;
    assign wr_in_range = (wr_x < X_LIM) && (wr_y < Y_LIM);
    assign wr_addr     = row_base({1'b0, wr_y}) + {7'b0, wr_x};

    // Prefetch target: the group after the current one in raster order.
    // The last group of a line wraps to the first group of the next line,
    // which stays in the same RAM row until the 4-line band is finished.
    always_comb begin
        fetch_addr = '0;
        if (grp != G_LAST)
            fetch_addr = row_base(row) + {7'b0, grp} + 15'd1;
        else if (next_y[1:0] != 2'd3)
            fetch_addr = row_base(row);
        else if (row != R_LAST)
            fetch_addr = row_base(row + 8'd1);
        else
            fetch_addr = '0;
    end

    // Port arbitration: the read slot always wins; the writer gets any other
    // cycle, but never two in a row so each grant is a single ack pulse.
    always_comb begin
        addr_nxt  = mem_addr;
        we_nxt    = 1'b0;
        wdata_nxt = mem_wdata;
        ack_nxt   = 1'b0;
        err_nxt   = wr_err;
        if (slot) begin
            addr_nxt = fetch_addr;
        end else if (wr_req && !wr_ack && blank_ok) begin
            ack_nxt   = 1'b1;
            addr_nxt  = wr_addr;
            wdata_nxt = wr_data;
            if (wr_in_range)
                we_nxt = 1'b1;
            else
                err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            wr_ack      <= 1'b0;
            wr_err      <= 1'b0;
            frame_start <= 1'b0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            hold        <= '0;
            color_out   <= '0;
        end else begin
            // p0: read address (or write) registered towards the RAM
            mem_addr    <= addr_nxt;
            mem_we      <= we_nxt;
            mem_wdata   <= wdata_nxt;
            wr_ack      <= ack_nxt;
            wr_err      <= err_nxt;
            frame_start <= (next_x == 10'd0) && (next_y == 10'd0);
            vld_p0      <= slot;
            // p1: RAM has sampled the address, data appears after this edge
            vld_p1      <= vld_p0;
            // p2: capture read data; it waits here until the next slot
            if (vld_p1)
                hold <= mem_rdata;
            if (slot)
                color_out <= hold;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  next_x, next_y;
    logic        wr_req, wr_req_b;
    logic [7:0]  wr_x, wr_data;
    logic [6:0]  wr_y;

    logic [7:0]  color_out, mem_wdata, mem_rdata;
    logic        frame_start, wr_ack, wr_err, mem_we;
    logic [14:0] mem_addr;

    logic [7:0]  color_out_b, mem_wdata_b, rdata_b;
    logic        frame_start_b, wr_ack_b, wr_err_b, mem_we_b;
    logic [14:0] mem_addr_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #20 clock = ~clock;

    vga_fb_arbiter #(.WR_BLANK_ONLY(0)) dut (
        .clock(clock), .reset(reset), .next_x(next_x), .next_y(next_y),
        .color_out(color_out), .frame_start(frame_start),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign rdata_b = 8'h00;

    vga_fb_arbiter #(.WR_BLANK_ONLY(1)) dut_b (
        .clock(clock), .reset(reset), .next_x(next_x), .next_y(next_y),
        .color_out(color_out_b), .frame_start(frame_start_b),
        .wr_req(wr_req_b), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_ack(wr_ack_b), .wr_err(wr_err_b),
        .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(rdata_b)
    );

    // Frame-buffer RAM: contents loaded at the first edge, then synchronous
    // read with data valid after the sampling edge.
    logic [7:0] ram [19200];
    bit         loaded = 1'b0;
    int         seed;

    function automatic logic [7:0] fill(input int i, input int s);
        if (i >= 160 && i < 320) return 8'(i - 160);
        return 8'(((i * 37) + s) ^ (i >> 3));
    endfunction

    always @(posedge clock) begin
        if (!loaded) begin
            for (int i = 0; i < 19200; i++) ram[i] <= fill(i, seed);
            loaded <= 1'b1;
        end else begin
            if (mem_we && mem_addr < 15'd19200) ram[mem_addr] <= mem_wdata;
            mem_rdata <= (mem_addr < 15'd19200) ? ram[mem_addr] : 8'h00;
        end
    end

    // Reference model state
    int          m_pend;
    logic [7:0]  m_color, m_wdata;
    logic [14:0] m_addr;
    logic        m_ack, m_we, m_err, m_fs, m_ack_b;

    // Next group to display in raster order (line wrap, frame wrap).
    function automatic int exp_fetch(input int x, input int y);
        int gx, ly;
        gx = x / 4 + 1;
        ly = y;
        if (gx == 160) begin
            gx = 0;
            ly = (y + 1) % 480;
        end
        return (ly / 4) * 160 + gx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = -1; m_color = '0; m_wdata = '0; m_addr = '0;
        m_ack = 0; m_we = 0; m_err = 0; m_fs = 0; m_ack_b = 0;
    endtask

    task automatic compare_all();
        chk("color_out",   color_out,   m_color);
        chk("frame_start", frame_start, m_fs);
        chk("wr_ack",      wr_ack,      m_ack);
        chk("wr_err",      wr_err,      m_err);
        chk("mem_addr",    mem_addr,    m_addr);
        chk("mem_we",      mem_we,      m_we);
        chk("mem_wdata",   mem_wdata,   m_wdata);
        chk("wr_ack_blank_only", wr_ack_b, m_ack_b);
    endtask

    // One clock: predict the effect of the edge from current inputs, clock,
    // then compare every output.
    task automatic cycle();
        int x, y, wa;
        bit vis, slot;
        x = int'(next_x);
        y = int'(next_y);
        vis  = (x < 640) && (y < 480);
        slot = vis && (x % 4 == 0);
        if (reset) begin
            model_reset();
        end else begin
            automatic bit ack_prev = m_ack;
            automatic bit ackb_prev = m_ack_b;
            m_fs = (x == 0) && (y == 0);
            m_ack = 0; m_we = 0; m_ack_b = 0;
            if (slot) begin
                m_addr  = 15'(exp_fetch(x, y));
                m_color = (m_pend < 0) ? 8'h00 : ram[m_pend];
                m_pend  = exp_fetch(x, y);
            end else if (wr_req && !ack_prev) begin
                wa = int'(wr_y) * 160 + int'(wr_x);
                m_ack   = 1;
                m_addr  = 15'(wa);
                m_wdata = wr_data;
                if (wr_x < 160 && wr_y < 120) m_we = 1;
                else m_err = 1;
            end
            if (!vis && wr_req_b && !ackb_prev) m_ack_b = 1;
        end
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic scan_line(input int y, input int blank, input bit rw);
        int lat;
        lat = 0;
        for (int x = 0; x < 640 + blank; x++) begin
            next_x = 10'(x);
            next_y = 10'(y);
            if (rw && !wr_req && !m_ack && $urandom_range(0, 3) == 0) begin
                wr_req  = 1'b1;
                wr_x    = 8'($urandom_range(0, 159));
                wr_y    = 7'($urandom_range(100, 119));
                wr_data = 8'($urandom);
                lat = 0;
            end
            cycle();
            if (y == 0 && x == 0) chk("frame_start_pulse", frame_start, 1);
            if (x < 640 && x % 4 == 0) begin
                if (y == 0)               chk("fetch_y0", mem_addr, (x == 636) ? 0 : x / 4 + 1);
                if (y == 3 && x == 636)   chk("fetch_y3_end", mem_addr, 160);
                if (y == 479 && x == 636) chk("fetch_frame_wrap", mem_addr, 0);
                if (y == 5)               chk("color_k", color_out, x / 4);
            end
            if (rw && wr_req) begin
                lat++;
                if (wr_ack) begin
                    chk("grant_latency_le2", 32'(lat <= 2), 1);
                    wr_req = 1'b0;
                end
            end
        end
    endtask

    initial begin
        seed = $urandom;
        reset = 1'b1;
        next_x = 10'd700; next_y = 10'd500;
        wr_req = 0; wr_req_b = 0; wr_x = 0; wr_y = 0; wr_data = 0;
        model_reset();

        // Reset state
        repeat (3) cycle();
        reset = 1'b0;
        next_x = 10'd700;
        cycle();

        // Fetch addresses and colour over consecutive lines, then frame wrap
        for (int y = 0; y < 6; y++) scan_line(y, $urandom_range(2, 12), 0);
        scan_line(479, 4, 0);

        // Write handshake during blanking
        next_x = 10'd700; next_y = 10'd10;
        wr_x = 8'd5; wr_y = 7'd2; wr_data = 8'hA5; wr_req = 1'b1;
        cycle();
        chk("hs_ack", wr_ack, 1);
        chk("hs_addr", mem_addr, 325);
        chk("hs_we", mem_we, 1);
        chk("hs_wdata", mem_wdata, 8'hA5);
        wr_x = 8'($urandom_range(0, 159)); wr_y = 7'($urandom_range(60, 99));
        wr_data = 8'($urandom);
        cycle();
        chk("hs_no_back_to_back", wr_ack, 0);
        cycle();
        chk("hs_second_grant", wr_ack, 1);
        wr_req = 1'b0;
        cycle();

        // Collision with a read slot; blank-only instance waits for blanking
        for (int x = 0; x < 648; x++) begin
            next_x = 10'(x); next_y = 10'd20;
            if (x == 8) begin
                wr_req = 1'b1; wr_req_b = 1'b1;
                wr_x = 8'($urandom_range(0, 159)); wr_y = 7'd110;
                wr_data = 8'($urandom);
            end
            cycle();
            if (x == 8) begin
                chk("coll_read_addr", mem_addr, 5 * 160 + 3);
                chk("coll_read_no_ack", wr_ack, 0);
            end
            if (x == 9)   chk("coll_write_next_edge", wr_ack, 1);
            if (x == 639) chk("blank_only_wait", wr_ack_b, 0);
            if (x == 640) chk("blank_only_grant", wr_ack_b, 1);
            if (wr_ack)   wr_req = 1'b0;
            if (wr_ack_b) wr_req_b = 1'b0;
        end

        // Random writes interleaved with visible scan-out
        scan_line(40, 8, 1);
        scan_line(41, 8, 1);
        wr_req = 1'b0;
        cycle();
        cycle();

        // Out-of-range write: acked, not written, sticky error
        next_x = 10'd700; next_y = 10'd10;
        wr_x = 8'd160; wr_y = 7'd3; wr_data = 8'h3C; wr_req = 1'b1;
        cycle();
        chk("err_ack", wr_ack, 1);
        chk("err_we", mem_we, 0);
        chk("err_flag", wr_err, 1);
        wr_req = 1'b0;
        repeat (3) cycle();
        wr_x = 8'd0; wr_y = 7'd70; wr_req = 1'b1;
        cycle();
        wr_req = 1'b0;
        cycle();
        chk("err_sticky", wr_err, 1);

        // Asynchronous reset mid-line with a write pending
        for (int x = 0; x <= 8; x++) begin
            next_x = 10'(x); next_y = 10'd30;
            if (x == 8) begin
                wr_x = 8'd7; wr_y = 7'd90; wr_data = 8'h5A; wr_req = 1'b1;
            end
            cycle();
        end
        next_x = 10'd9;
        #5;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("rst_err_cleared", wr_err, 0);
        repeat (2) cycle();
        chk("rst_no_ack", wr_ack, 0);
        wr_req = 1'b0;
        reset = 1'b0;
        next_x = 10'd700; next_y = 10'd500;
        cycle();
        scan_line(0, 4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
